// File: rtl/store_commit_scheduler.sv
// store_commit_scheduler: drains ROB-retired stores from the STQ head to the
// data cache one at a time. After each completed write it pulses stq_commit so
// the order failure detector can report misordered younger loads, and if any
// did, it raises a flush for the oldest of them and holds off further draining
// until the ROB accepts the flush.
module store_commit_scheduler #(
    parameter int XLEN     = 32,
    parameter int LDQ_SIZE = 32,
    parameter int STQ_SIZE = 32
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  rob_commit_store,
    input  logic [$clog2(STQ_SIZE)-1:0]           stq_head,
    input  logic [STQ_SIZE-1:0]                   stq_valid,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]         stq_address,
    input  logic [STQ_SIZE-1:0][XLEN-1:0]         stq_data,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic [XLEN-1:0]                       mem_req_address,
    output logic [XLEN-1:0]                       mem_req_data,
    input  logic                                  mem_resp_valid,
    output logic                                  stq_commit,
    output logic [$clog2(STQ_SIZE)-1:0]           stq_commit_index,
    output logic                                  stq_dequeue,
    input  logic [LDQ_SIZE-1:0]                   order_failures,
    input  logic [$clog2(LDQ_SIZE)-1:0]           ldq_head,
    output logic                                  flush_valid,
    output logic [$clog2(LDQ_SIZE)-1:0]           flush_ldq_index,
    input  logic                                  flush_ready
);

    localparam int SW = $clog2(STQ_SIZE);
    localparam int LW = $clog2(LDQ_SIZE);
    localparam int PW = SW + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_ACK = 3'd2,
        CHECK    = 3'd3,
        FLUSH    = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   pending;
    logic [SW-1:0]   idx_q;
    logic [XLEN-1:0] addr_q, data_q;
    logic [LW-1:0]   flush_idx_q;
    logic [LW-1:0]   oldest, cand;
    logic            start, pend_inc, pend_dec;

    // A drain can only begin from IDLE with a retired store whose entry is valid.
    assign start    = (state == IDLE) && (pending != '0) && stq_valid[stq_head];
    // A retire while the counter is already full is dropped rather than wrapping.
    assign pend_inc = rob_commit_store && (pending != PW'(STQ_SIZE));
    assign pend_dec = (state == CHECK);

    // State register; reset abandons any request or flush in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and output decode.
    always_comb begin
        state_nx      = state;
        mem_req_valid = 1'b0;
        stq_commit    = 1'b0;
        stq_dequeue   = 1'b0;
        flush_valid   = 1'b0;
        case (state)
            IDLE:     if (start) state_nx = SEND;
            SEND: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nx = WAIT_ACK;
            end
            WAIT_ACK: if (mem_resp_valid) state_nx = CHECK;
            CHECK: begin
                stq_commit  = 1'b1;
                stq_dequeue = 1'b1;
                state_nx    = (|order_failures) ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_valid = 1'b1;
                if (flush_ready) state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
    end

    // Oldest failing load: scan from the youngest distance down to ldq_head so
    // the smallest (i - ldq_head) mod LDQ_SIZE is the last one written.
    always_comb begin
        oldest = '0;
        cand   = '0;
        for (int k = LDQ_SIZE - 1; k >= 0; k--) begin
            cand = ldq_head + LW'(k);
            if (order_failures[cand]) oldest = cand;
        end
    end

    // Retired-but-undrained store count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            case ({pend_inc, pend_dec})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    // Capture the head store when a drain starts so the request stays stable,
    // and capture the flush target while the detector result is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            flush_idx_q <= '0;
        end else begin
            if (start) begin
                idx_q  <= stq_head;
                addr_q <= stq_address[stq_head];
                data_q <= stq_data[stq_head];
            end
            if (state == CHECK && (|order_failures)) flush_idx_q <= oldest;
        end
    end

    assign mem_req_address  = addr_q;
    assign mem_req_data     = data_q;
    assign stq_commit_index = idx_q;
    assign flush_ldq_index  = flush_idx_q;

endmodule

// File: tb/tb_store_commit_scheduler.sv
// Bench for store_commit_scheduler: directed scenarios, a flag-level reference
// model of the drain/commit/flush protocol checked every negedge, and literal
// expectations at key points of each scenario.
module tb_store_commit_scheduler;

    localparam int XLEN = 32;
    localparam int LDQ  = 32;
    localparam int STQ  = 32;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b1;
    logic                       rob_commit_store = 1'b0;
    logic [4:0]                 stq_head = '0;
    logic [STQ-1:0]             stq_valid = '0;
    logic [STQ-1:0][XLEN-1:0]   stq_address = '0;
    logic [STQ-1:0][XLEN-1:0]   stq_data = '0;
    logic                       mem_req_valid;
    logic                       mem_req_ready = 1'b0;
    logic [XLEN-1:0]            mem_req_address, mem_req_data;
    logic                       mem_resp_valid = 1'b0;
    logic                       stq_commit;
    logic [4:0]                 stq_commit_index;
    logic                       stq_dequeue;
    logic [LDQ-1:0]             order_failures;
    logic [4:0]                 ldq_head = '0;
    logic                       flush_valid;
    logic [4:0]                 flush_ldq_index;
    logic                       flush_ready = 1'b0;

    // Detector stand-in: reports the current failure pattern during a commit.
    logic [LDQ-1:0]             fail_pat = '0;
    assign order_failures = stq_commit ? fail_pat : '0;

    store_commit_scheduler #(.XLEN(XLEN), .LDQ_SIZE(LDQ), .STQ_SIZE(STQ)) dut (
        .clk(clk), .reset_n(reset_n), .rob_commit_store(rob_commit_store),
        .stq_head(stq_head), .stq_valid(stq_valid), .stq_address(stq_address),
        .stq_data(stq_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_address(mem_req_address), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .stq_commit(stq_commit),
        .stq_commit_index(stq_commit_index), .stq_dequeue(stq_dequeue),
        .order_failures(order_failures), .ldq_head(ldq_head), .flush_valid(flush_valid),
        .flush_ldq_index(flush_ldq_index), .flush_ready(flush_ready)
    );

    always #5 clk = ~clk;

    // Reference model: one store in flight, tracked as request/await/commit/flush flags.
    bit          m_req = 0, m_wait = 0, m_commit = 0, m_flush = 0;
    int          m_pend = 0, m_idx = 0, m_fl = 0;
    logic [31:0] m_addr = '0, m_data = '0;

    function automatic int oldest_of(input logic [LDQ-1:0] v, input int head);
        int best = 0;
        int bd = LDQ;
        for (int i = 0; i < LDQ; i++) begin
            if (v[i] && ((i - head + LDQ) % LDQ) < bd) begin
                bd = (i - head + LDQ) % LDQ;
                best = i;
            end
        end
        return best;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_req <= 0; m_wait <= 0; m_commit <= 0; m_flush <= 0;
            m_pend <= 0; m_idx <= 0; m_fl <= 0; m_addr <= '0; m_data <= '0;
        end else begin
            if (m_commit) begin
                m_commit <= 0;
                if (fail_pat != '0) begin
                    m_flush <= 1;
                    m_fl    <= oldest_of(fail_pat, int'(ldq_head));
                end
            end else if (m_flush) begin
                if (flush_ready) m_flush <= 0;
            end else if (m_wait) begin
                if (mem_resp_valid) begin m_wait <= 0; m_commit <= 1; end
            end else if (m_req) begin
                if (mem_req_ready) begin m_req <= 0; m_wait <= 1; end
            end else if (m_pend > 0 && stq_valid[stq_head]) begin
                m_req  <= 1;
                m_idx  <= int'(stq_head);
                m_addr <= stq_address[stq_head];
                m_data <= stq_data[stq_head];
            end
            m_pend <= m_pend + ((rob_commit_store && m_pend < STQ) ? 1 : 0) - (m_commit ? 1 : 0);
        end
    end

    int tests = 0, errs = 0;
    int req_cnt = 0, deq_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // which: 0 = mem_req_valid, 1 = stq_commit, 2 = flush_valid
    task automatic wait_sig(input int which, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && mem_req_valid) || (which == 1 && stq_commit) ||
                (which == 2 && flush_valid)) return;
            tick();
        end
        tests++;
        errs++;
        $display("FAIL %s: timed out after %0d cycles", name, budget);
    endtask

    task automatic compare();
        chk("req_valid", {31'd0, mem_req_valid}, {31'd0, m_req});
        if (m_req) begin
            chk("req_addr", mem_req_address, m_addr);
            chk("req_data", mem_req_data, m_data);
        end
        chk("commit", {31'd0, stq_commit}, {31'd0, m_commit});
        chk("dequeue", {31'd0, stq_dequeue}, {31'd0, m_commit});
        if (m_commit) chk("commit_idx", {27'd0, stq_commit_index}, m_idx);
        chk("flush_valid", {31'd0, flush_valid}, {31'd0, m_flush});
        if (m_flush) chk("flush_idx", {27'd0, flush_ldq_index}, m_fl);
        chk("pending", {26'd0, dut.pending}, m_pend);
        if (mem_req_valid) req_cnt++;
        if (stq_dequeue) deq_cnt++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},   {31'd0, mem_req_valid}, 32'd0);
        chk({tag, "_addr"},  mem_req_address, 32'd0);
        chk({tag, "_data"},  mem_req_data, 32'd0);
        chk({tag, "_cmt"},   {31'd0, stq_commit}, 32'd0);
        chk({tag, "_cidx"},  {27'd0, stq_commit_index}, 32'd0);
        chk({tag, "_deq"},   {31'd0, stq_dequeue}, 32'd0);
        chk({tag, "_flush"}, {31'd0, flush_valid}, 32'd0);
        chk({tag, "_fidx"},  {27'd0, flush_ldq_index}, 32'd0);
        chk({tag, "_pend"},  {26'd0, dut.pending}, 32'd0);
    endtask

    initial begin
        int rq, dq;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        // Reset state
        #1 reset_n = 1'b0;
        #2 check_zero("reset");
        tick();
        reset_n = 1'b1;

        // Single store, immediate ready and response
        stq_head = 5'd3; stq_valid[3] = 1'b1;
        stq_address[3] = 32'h100; stq_data[3] = 32'hDEAD;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        rq = req_cnt;
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        wait_sig(1, 20, "single_commit");
        chk("single_idx", {27'd0, stq_commit_index}, 32'd3);
        chk("single_deq", {31'd0, stq_dequeue}, 32'd1);
        tick();
        chk("single_pend", {26'd0, dut.pending}, 32'd0);
        chk("single_reqcyc", req_cnt - rq, 32'd1);
        chk("single_noflush", {31'd0, flush_valid}, 32'd0);

        // Backpressure: ready low for 5 request cycles, late response
        stq_head = 5'd4; stq_valid[4] = 1'b1;
        stq_address[4] = 32'h200; stq_data[4] = 32'hBEEF;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        rq = req_cnt;
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        wait_sig(0, 20, "bp_req");
        chk("bp_addr", mem_req_address, 32'h200);
        repeat (5) tick();
        chk("bp_data_stable", mem_req_data, 32'hBEEF);
        mem_req_ready = 1'b1;
        tick();
        chk("bp_reqcyc", req_cnt - rq, 32'd6);
        repeat (2) tick();
        chk("bp_no_commit", {31'd0, stq_commit}, 32'd0);
        mem_resp_valid = 1'b1;
        wait_sig(1, 5, "bp_commit");
        chk("bp_idx", {27'd0, stq_commit_index}, 32'd4);
        tick();

        // Order failure with LDQ wrap: head 30, failures {1,5,31} -> 31
        ldq_head = 5'd30; fail_pat = 32'h8000_0022; flush_ready = 1'b0;
        stq_head = 5'd5; stq_valid[5] = 1'b1; stq_valid[6] = 1'b1;
        stq_address[5] = 32'h300; stq_data[5] = 32'h1234;
        stq_address[6] = 32'h304; stq_data[6] = 32'h5678;
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        wait_sig(1, 20, "flush_commit");
        stq_head = 5'd6;
        tick();
        chk("flush_valid", {31'd0, flush_valid}, 32'd1);
        chk("flush_idx31", {27'd0, flush_ldq_index}, 32'd31);
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_noreq", {31'd0, mem_req_valid}, 32'd0);
            tick();
        end
        chk("flush_hold", {27'd0, flush_ldq_index}, 32'd31);
        flush_ready = 1'b1; tick(); flush_ready = 1'b0; fail_pat = '0;
        chk("flush_drop", {31'd0, flush_valid}, 32'd0);
        wait_sig(1, 20, "after_flush_commit");
        chk("after_flush_idx", {27'd0, stq_commit_index}, 32'd6);
        tick();

        // Retire in the CHECK cycle with pending==1
        stq_head = 5'd7; stq_valid[7] = 1'b1; stq_valid[8] = 1'b1;
        stq_address[8] = 32'h800; stq_data[8] = 32'h8888;
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        wait_sig(1, 20, "simul_commit");
        rob_commit_store = 1'b1; stq_head = 5'd8;
        tick();
        rob_commit_store = 1'b0;
        chk("simul_pend", {26'd0, dut.pending}, 32'd1);
        tick();
        chk("simul_nogap", {31'd0, mem_req_valid}, 32'd1);
        chk("simul_addr", mem_req_address, 32'h800);
        wait_sig(1, 20, "simul_commit2");
        chk("simul_idx", {27'd0, stq_commit_index}, 32'd8);
        tick();

        // Three queued stores drain in order
        for (int i = 10; i < 13; i++) begin
            stq_valid[i] = 1'b1;
            stq_address[i] = 32'h1000 + 32'(i) * 4;
            stq_data[i] = 32'(i) * 32'h111;
        end
        stq_head = 5'd10;
        dq = deq_cnt;
        rob_commit_store = 1'b1; repeat (3) tick(); rob_commit_store = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_sig(1, 30, "three_commit");
            chk("three_idx", {27'd0, stq_commit_index}, 32'(10 + k));
            stq_head = 5'(11 + k);
            tick();
        end
        repeat (2) tick();
        chk("three_deq", deq_cnt - dq, 32'd3);
        chk("three_pend", {26'd0, dut.pending}, 32'd0);

        // Reset while waiting for the write response
        stq_head = 5'd13; stq_valid[13] = 1'b1; stq_address[13] = 32'hD00;
        mem_resp_valid = 1'b0;
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        wait_sig(0, 20, "rst_wait_req");
        tick();
        reset_n = 1'b0;
        #1 check_zero("rst_wait");
        tick(); tick();
        reset_n = 1'b1; mem_resp_valid = 1'b1;
        repeat (4) tick();
        chk("late_resp_nocommit", {31'd0, stq_commit}, 32'd0);
        chk("late_resp_noreq", {31'd0, mem_req_valid}, 32'd0);

        // Reset while holding a flush
        ldq_head = 5'd0; fail_pat = 32'h0000_0008;
        rob_commit_store = 1'b1; tick(); rob_commit_store = 1'b0;
        wait_sig(1, 20, "rst_flush_commit");
        tick();
        chk("rst_flush_idx3", {27'd0, flush_ldq_index}, 32'd3);
        reset_n = 1'b0;
        #1 check_zero("rst_flush");
        tick();
        reset_n = 1'b1; fail_pat = '0;
        tick();

        // Pending saturates at STQ_SIZE
        stq_valid = '0;
        rob_commit_store = 1'b1; repeat (34) tick(); rob_commit_store = 1'b0;
        chk("pend_sat", {26'd0, dut.pending}, 32'd32);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/store_commit_scheduler.md
Name: store_commit_scheduler

Overview:
- Drains ROB-retired stores from the STQ head to the data cache one at a time.
- Announces each completed write to the order failure detector via stq_commit/stq_commit_index, then samples the detector's order_failures vector.
- If any younger load misordered, selects the oldest failing load and holds a flush request to the ROB until acknowledged; draining stalls meanwhile.
- Sits between ROB commit, STQ, D-cache write port and order failure detector.

Parameters:
XLEN, 32, data/address width
LDQ_SIZE, 32, load queue entries (power of two)
STQ_SIZE, 32, store queue entries (power of two)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
rob_commit_store  input  1  pulse: ROB retired the next undrained store
stq_head  input  $clog2(STQ_SIZE)  index of oldest STQ entry
stq_valid  input  STQ_SIZE  per-entry valid
stq_address  input  STQ_SIZE x XLEN  per-entry address
stq_data  input  STQ_SIZE x XLEN  per-entry data
mem_req_valid  output  1  write request valid
mem_req_ready  input  1  cache accepts request
mem_req_address  output  XLEN  write address
mem_req_data  output  XLEN  write data
mem_resp_valid  input  1  write-complete pulse
stq_commit  output  1  one-cycle pulse to detector
stq_commit_index  output  $clog2(STQ_SIZE)  committing store index
stq_dequeue  output  1  one-cycle pulse: pop STQ head
order_failures  input  LDQ_SIZE  detector result (combinational from stq_commit)
ldq_head  input  $clog2(LDQ_SIZE)  index of oldest LDQ entry
flush_valid  output  1  flush request to ROB
flush_ldq_index  output  $clog2(LDQ_SIZE)  oldest misordered load
flush_ready  input  1  ROB accepts flush

Behaviour:
- Reset (async, reset_n=0): state IDLE, pending=0, all outputs 0 including indices, address, data.
- pending counter, width $clog2(STQ_SIZE)+1:
  - +1 on rob_commit_store, -1 on stq_dequeue; both in the same cycle leave it unchanged.
  - rob_commit_store while pending==STQ_SIZE is ignored (no wrap).
- FSM:
  - IDLE: if pending>0 and stq_valid[stq_head], latch idx=stq_head and the address/data at that index, then go to SEND.
  - SEND: mem_req_valid=1; address/data stay stable from the latched values. On mem_req_ready, go to WAIT_ACK. The request is never withdrawn before acceptance.
  - WAIT_ACK: on mem_resp_valid, go to CHECK. A mem_resp_valid in any other state is ignored.
  - CHECK (exactly one cycle):
    - stq_commit=1, stq_commit_index=idx, stq_dequeue=1; order_failures sampled this cycle.
    - If order_failures!=0: register flush_ldq_index, go to FLUSH.
    - Otherwise go to IDLE.
  - FLUSH: flush_valid=1 with flush_ldq_index stable. On flush_ready, go to IDLE. No new drain starts while in FLUSH. pending is unchanged by the flush, because stores older than the failing load stay architecturally retired.
- Oldest-failure selection: among set bits i, choose the minimum (i - ldq_head) mod LDQ_SIZE. This handles wrap-around, e.g. ldq_head=30 makes 31 older than 0.
- Minimum per-store latency: IDLE→SEND 1 cycle, SEND→WAIT_ACK on ready, WAIT_ACK→CHECK on response, CHECK→IDLE 1 cycle. Back-to-back stores with ready/response same-cycle take 4 cycles each.
- stq_commit and stq_dequeue are asserted only in CHECK, never more than one cycle per store.
- Reset mid-operation: any outstanding request or flush is abandoned and outputs drop to 0 immediately.

Test Plan:
- Single store: reset, rob_commit_store pulse, stq_head=3, stq_valid[3]=1, addr 0x100, data 0xDEAD, ready and response immediate → mem_req_valid for 1 cycle with 0x100/0xDEAD; stq_commit=1, stq_commit_index=3, stq_dequeue=1 in CHECK; pending returns to 0; flush_valid stays 0.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid held 5+1 cycles with stable address/data; stq_commit fires only after mem_resp_valid.
- Order failure with wrap: ldq_head=30, order_failures bits {1,31,5} in CHECK → flush_valid=1, flush_ldq_index=31, held until flush_ready; no mem_req_valid during FLUSH.
- Simultaneous events: rob_commit_store pulsed in the CHECK cycle with pending=1 → pending stays 1; the next store drains without a gap beyond IDLE.
- Three retired stores queued (pending=3) → three sequential drains with stq_commit_index following stq_head; pending ends at 0; stq_dequeue pulsed exactly 3 times.
- Reset asserted in WAIT_ACK and in FLUSH → outputs 0 asynchronously, state IDLE, pending 0; a late mem_resp_valid after reset release is ignored.
